// File: rtl/aes_loader_pkg.sv
// Shared constants for the masked AES share loader.
// State encoding and block geometry.
package aes_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    LOAD_PT  = 2'd2,
    FULL     = 2'd3
  } state_e;

  localparam int WORDS_PER_BLOCK = 4;
  localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

endpackage

// File: rtl/aes_share_wordreg.sv
// 128*D share register written one 32-bit column at a time.
// Every share keeps its own lane; shares are never combined.
module aes_share_wordreg #(
  parameter int D = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [1:0]      idx_i,
  input  logic [32*D-1:0] data_i,
  output logic [128*D-1:0] q_o
);

  logic [128*D-1:0] q_q;
  logic [128*D-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) begin
      for (int s = 0; s < D; s++) begin
        q_d[128*s + 32*int'(idx_i) +: 32] = data_i[32*s +: 32];
      end
    end
    if (clr_i) q_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/aes_share_loader32.sv
// Collects masked key/plaintext columns into full share buses
// for the masked AES core, with key reuse across blocks.
module aes_share_loader32
  import aes_loader_pkg::*;
#(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*d-1:0]  in_data,
  input  logic             in_key_reuse,
  input  logic             in_abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] out_shares_plaintext,
  output logic [128*d-1:0] out_shares_key,
  output logic             key_loaded
);

  state_e     state_q;
  logic [1:0] cnt_q;
  logic       key_loaded_q;
  logic       in_ready_q;
  logic       out_valid_q;

  logic acc;
  logic reuse;
  logic key_we;
  logic pt_we;
  logic key_clr;
  logic pt_clr;

  assign acc   = in_valid & in_ready_q;
  assign reuse = in_key_reuse & key_loaded_q;

  always_comb begin
    key_we  = 1'b0;
    pt_we   = 1'b0;
    key_clr = 1'b0;
    pt_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        key_we = acc & ~reuse;
        pt_we  = acc & reuse;
      end
      LOAD_KEY: begin
        key_we  = acc & ~in_abort;
        key_clr = in_abort;
        pt_clr  = in_abort;
      end
      LOAD_PT: begin
        pt_we  = acc & ~in_abort;
        pt_clr = in_abort;
      end
      FULL: pt_clr = out_ready;
    endcase
  end

  // Handshake flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      key_loaded_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            cnt_q <= 2'd1;
            if (reuse) begin
              state_q <= LOAD_PT;
            end else begin
              state_q      <= LOAD_KEY;
              key_loaded_q <= 1'b0;
            end
          end
        end
        LOAD_KEY: begin
          if (in_abort) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
          end else if (acc) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == LAST_WORD) begin
              state_q      <= LOAD_PT;
              key_loaded_q <= 1'b1;
            end
          end
        end
        LOAD_PT: begin
          if (in_abort) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
          end else if (acc) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == LAST_WORD) begin
              state_q     <= FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  aes_share_wordreg #(.D(d)) u_key (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (key_clr),
    .we_i   (key_we),
    .idx_i  (cnt_q),
    .data_i (in_data),
    .q_o    (out_shares_key)
  );

  aes_share_wordreg #(.D(d)) u_pt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pt_clr),
    .we_i   (pt_we),
    .idx_i  (cnt_q),
    .data_i (in_data),
    .q_o    (out_shares_plaintext)
  );

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign key_loaded = key_loaded_q;

endmodule
